// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel-source modes, colour-bar table, timing helpers.
package vga_pkg;

  typedef enum logic [1:0] {
    PIX_EXT   = 2'd0,
    PIX_BARS  = 2'd1,
    PIX_CHECK = 2'd2,
    PIX_SOLID = 2'd3
  } pix_mode_e;

  // One {r,g,b} on/off triple per bar, bar 0 at the left edge:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  // Total clocks per line (or lines per frame) from the four timing segments.
  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed to index 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with visible-area and sync decode.
// All decoded outputs are combinational from the counter state and are
// forced idle while the block is not running (en low or in reset).
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'd800,
  parameter int unsigned H_FP     = 32'd40,
  parameter int unsigned H_SYNC   = 32'd128,
  parameter int unsigned H_BP     = 32'd88,
  parameter int unsigned V_ACTIVE = 32'd600,
  parameter int unsigned V_FP     = 32'd1,
  parameter int unsigned V_SYNC   = 32'd4,
  parameter int unsigned V_BP     = 32'd23,
  localparam int unsigned XW = cnt_width(H_ACTIVE),
  localparam int unsigned YW = cnt_width(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          active,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          hs_active,
  output logic          vs_active,
  output logic          frame_first
);

  localparam int unsigned H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW       = cnt_width(H_TOTAL);
  localparam int unsigned VW       = cnt_width(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if (H_FP == 32'd0 || H_SYNC == 32'd0 || H_BP == 32'd0 ||
      V_FP == 32'd0 || V_SYNC == 32'd0 || V_BP == 32'd0) begin : g_bad_timing
    $fatal(1, "vga_timing: porch and sync widths must be non-zero");
  end

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          run_s;
  logic          h_last_s;
  logic          v_last_s;

  // Reset is folded in so the decode is idle while reset is held.
  assign run_s    = en & reset;
  assign h_last_s = (h_cnt_q == HW'(H_TOTAL - 32'd1));
  assign v_last_s = (v_cnt_q == VW'(V_TOTAL - 32'd1));

  // Next counter state: park at 0,0 when stopped, otherwise raster-advance.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run_s) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_last_s) begin
      h_cnt_d = '0;
      if (v_last_s) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Visible-area, sync-window and frame-origin decode.
  always_comb begin
    active      = run_s && (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
    hs_active   = run_s && (32'(h_cnt_q) >= HS_START) && (32'(h_cnt_q) < HS_END);
    vs_active   = run_s && (32'(v_cnt_q) >= VS_START) && (32'(v_cnt_q) < VS_END);
    frame_first = run_s && (h_cnt_q == '0) && (v_cnt_q == '0);
    pix_x       = '0;
    pix_y       = '0;
    if (active) begin
      pix_x = h_cnt_q[XW-1:0];
      pix_y = v_cnt_q[YW-1:0];
    end else begin
      pix_x = '0;
      pix_y = '0;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: raster timing, pixel request, pattern select and a
// two-stage output pipeline. Stage 0 issues the request, stage 1 carries
// the delayed coordinates while the requested pixel arrives, stage 2
// registers every output so syncs, de, colour and frame_start line up.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'd800,
  parameter int unsigned H_FP     = 32'd40,
  parameter int unsigned H_SYNC   = 32'd128,
  parameter int unsigned H_BP     = 32'd88,
  parameter int unsigned V_ACTIVE = 32'd600,
  parameter int unsigned V_FP     = 32'd1,
  parameter int unsigned V_SYNC   = 32'd4,
  parameter int unsigned V_BP     = 32'd23,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned COLOR_W  = 32'd4,
  localparam int unsigned XW    = cnt_width(H_ACTIVE),
  localparam int unsigned YW    = cnt_width(V_ACTIVE),
  localparam int unsigned RGB_W = 32'd3 * COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [RGB_W-1:0]   solid_rgb,
  output logic               req_valid,
  output logic [XW-1:0]      req_x,
  output logic [YW-1:0]      req_y,
  input  logic [RGB_W-1:0]   pix_rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] grn,
  output logic [COLOR_W-1:0] blu,
  output logic               frame_start
);

  if (COLOR_W < 32'd1) begin : g_bad_color
    $fatal(1, "vga_scanout: COLOR_W must be at least 1");
  end

  // Stage 0: counters and decode.
  logic          t_active_s;
  logic [XW-1:0] t_x_s;
  logic [YW-1:0] t_y_s;
  logic          t_hs_s;
  logic          t_vs_s;
  logic          t_first_s;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .active      (t_active_s),
    .pix_x       (t_x_s),
    .pix_y       (t_y_s),
    .hs_active   (t_hs_s),
    .vs_active   (t_vs_s),
    .frame_first (t_first_s)
  );

  assign req_valid = t_active_s;
  assign req_x     = t_x_s;
  assign req_y     = t_y_s;

  // Stage 1 registers: request context delayed to meet the returned pixel.
  logic          s1_valid_q, s1_valid_d;
  logic [XW-1:0] s1_x_q,     s1_x_d;
  logic [YW-1:0] s1_y_q,     s1_y_d;
  logic          s1_hs_q,    s1_hs_d;
  logic          s1_vs_q,    s1_vs_d;
  logic          s1_fs_q,    s1_fs_d;

  // Stage 2 registers: the block outputs.
  logic             de_q,    de_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [RGB_W-1:0] rgb_q,   rgb_d;
  logic             fs_q,    fs_d;

  pix_mode_e        mode_s;
  logic [2:0]       bar_idx_s;
  logic [2:0]       bar_s;
  logic             check_dark_s;
  logic [RGB_W-1:0] pat_rgb_s;

  assign mode_s       = pix_mode_e'(mode);
  // Bar index x*8/H_ACTIVE; x < H_ACTIVE keeps the quotient within 0..7.
  assign bar_idx_s    = 3'((32'(s1_x_q) << 3) / H_ACTIVE);
  assign bar_s        = BAR_TABLE[bar_idx_s];
  // 16x16 checker cells: bit 4 of x xor bit 4 of y.
  assign check_dark_s = (((32'(s1_x_q) ^ 32'(s1_y_q)) & 32'h0000_0010) != 32'h0);

  // Stage 0 -> stage 1 transfer.
  always_comb begin
    s1_valid_d = t_active_s;
    s1_x_d     = t_x_s;
    s1_y_d     = t_y_s;
    s1_hs_d    = t_hs_s;
    s1_vs_d    = t_vs_s;
    s1_fs_d    = t_first_s;
  end

  // Pixel source select on the delayed coordinates; mode is live so a
  // change lands on the very next pixel.
  always_comb begin
    pat_rgb_s = '0;
    case (mode_s)
      PIX_EXT:   pat_rgb_s = pix_rgb;
      PIX_BARS:  pat_rgb_s = {{COLOR_W{bar_s[2]}}, {COLOR_W{bar_s[1]}}, {COLOR_W{bar_s[0]}}};
      PIX_CHECK: pat_rgb_s = check_dark_s ? '0 : '1;
      PIX_SOLID: pat_rgb_s = solid_rgb;
      default:   pat_rgb_s = '0;
    endcase
  end

  // Stage 1 -> stage 2: apply sync polarity and blank colour outside de.
  always_comb begin
    de_d    = s1_valid_q;
    hsync_d = s1_hs_q ? HS_POL : ~HS_POL;
    vsync_d = s1_vs_q ? VS_POL : ~VS_POL;
    fs_d    = s1_fs_q;
    if (s1_valid_q) begin
      rgb_d = pat_rgb_s;
    end else begin
      rgb_d = '0;
    end
  end

  // Pipeline registers; reset leaves syncs at their inactive level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_hs_q    <= 1'b0;
      s1_vs_q    <= 1'b0;
      s1_fs_q    <= 1'b0;
      de_q       <= 1'b0;
      hsync_q    <= ~HS_POL;
      vsync_q    <= ~VS_POL;
      rgb_q      <= '0;
      fs_q       <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_hs_q    <= s1_hs_d;
      s1_vs_q    <= s1_vs_d;
      s1_fs_q    <= s1_fs_d;
      de_q       <= de_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      rgb_q      <= rgb_d;
      fs_q       <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign red         = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign grn         = rgb_q[2*COLOR_W-1:COLOR_W];
  assign blu         = rgb_q[COLOR_W-1:0];
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a default-timing instance and a tiny-timing
// instance run side by side against a cycle model of the raster and the
// two-clock output pipeline, plus directed event timing checks.
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance.
  logic        d_reset, d_en;
  logic [1:0]  d_mode;
  logic [11:0] d_solid, d_pix;
  logic        d_req_valid;
  logic [9:0]  d_req_x, d_req_y;
  logic        d_hsync, d_vsync, d_de, d_fs;
  logic [3:0]  d_red, d_grn, d_blu;

  // Small configuration instance: 8x4 visible, every porch/sync 1, hsync active low.
  logic        s_reset, s_en;
  logic [1:0]  s_mode;
  logic [11:0] s_solid, s_pix;
  logic        s_req_valid;
  logic [2:0]  s_req_x;
  logic [1:0]  s_req_y;
  logic        s_hsync, s_vsync, s_de, s_fs;
  logic [3:0]  s_red, s_grn, s_blu;

  vga_scanout u_dflt (
    .clk(clk), .reset(d_reset), .en(d_en), .mode(d_mode), .solid_rgb(d_solid),
    .req_valid(d_req_valid), .req_x(d_req_x), .req_y(d_req_y), .pix_rgb(d_pix),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
    .red(d_red), .grn(d_grn), .blu(d_blu), .frame_start(d_fs)
  );

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(s_reset), .en(s_en), .mode(s_mode), .solid_rgb(s_solid),
    .req_valid(s_req_valid), .req_x(s_req_x), .req_y(s_req_y), .pix_rgb(s_pix),
    .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
    .red(s_red), .grn(s_grn), .blu(s_blu), .frame_start(s_fs)
  );

  // External pixel source: any fixed function of the requested coordinate.
  function automatic logic [11:0] ext_pix(input int x, input int y);
    int v;
    v = (x * 7) ^ (y * 45) ^ (y << 8);
    return v[11:0];
  endfunction

  // Pixel memory stand-in: answers each request on the following clock.
  always @(posedge clk) begin
    d_pix <= ext_pix(32'(d_req_x), 32'(d_req_y));
    s_pix <= ext_pix(32'(s_req_x), 32'(s_req_y));
  end

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Timing configuration per instance (0 = default, 1 = small).
  int ha[2]   = '{800, 8};
  int hf[2]   = '{40, 1};
  int hsw[2]  = '{128, 1};
  int hb[2]   = '{88, 1};
  int va[2]   = '{600, 4};
  int vf[2]   = '{1, 1};
  int vsw[2]  = '{4, 1};
  int vb[2]   = '{23, 1};
  bit hpol[2] = '{1'b1, 1'b0};
  bit vpol[2] = '{1'b1, 1'b1};
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  typedef struct { bit valid; int x; int y; bit hs; bit vs; bit fs; } st_t;
  typedef struct { bit de; bit hsync; bit vsync; logic [11:0] rgb; bit fs; } out_t;

  st_t  st0[2], st1[2];
  out_t st2[2];
  int   mh[2], mv[2];

  function automatic st_t idle_st();
    st_t s;
    s.valid = 1'b0; s.x = 0; s.y = 0; s.hs = 1'b0; s.vs = 1'b0; s.fs = 1'b0;
    return s;
  endfunction

  function automatic out_t reset_out(input int d);
    out_t o;
    o.de = 1'b0; o.hsync = !hpol[d]; o.vsync = !vpol[d]; o.rgb = 12'h000; o.fs = 1'b0;
    return o;
  endfunction

  function automatic st_t stage0(input int d);
    st_t s;
    bit  run;
    run     = (d == 0) ? (d_reset && d_en) : (s_reset && s_en);
    s.valid = run && (mh[d] < ha[d]) && (mv[d] < va[d]);
    s.x     = s.valid ? mh[d] : 0;
    s.y     = s.valid ? mv[d] : 0;
    s.hs    = run && (mh[d] >= ha[d] + hf[d]) && (mh[d] < ha[d] + hf[d] + hsw[d]);
    s.vs    = run && (mv[d] >= va[d] + vf[d]) && (mv[d] < va[d] + vf[d] + vsw[d]);
    s.fs    = run && (mh[d] == 0) && (mv[d] == 0);
    return s;
  endfunction

  function automatic logic [11:0] pattern(input int d, input int x, input int y);
    logic [1:0] m;
    m = (d == 0) ? d_mode : s_mode;
    case (m)
      2'd0:    return ext_pix(x, y);
      2'd1:    return bars[(x * 8) / ha[d]];
      2'd2:    return (((x ^ y) & 16) != 0) ? 12'h000 : 12'hFFF;
      2'd3:    return (d == 0) ? d_solid : s_solid;
      default: return 12'h000;
    endcase
  endfunction

  function automatic out_t finalize(input int d, input st_t s);
    out_t o;
    o.de    = s.valid;
    o.hsync = s.hs ? hpol[d] : !hpol[d];
    o.vsync = s.vs ? vpol[d] : !vpol[d];
    o.rgb   = s.valid ? pattern(d, s.x, s.y) : 12'h000;
    o.fs    = s.fs;
    return o;
  endfunction

  task automatic check_dut(input int d);
    logic [31:0] rv, rx, ry, de, hs, vs, rgb, fs;
    string p;
    if (d == 0) begin
      p = "dflt";
      rv = 32'(d_req_valid); rx = 32'(d_req_x); ry = 32'(d_req_y);
      de = 32'(d_de); hs = 32'(d_hsync); vs = 32'(d_vsync);
      rgb = 32'({d_red, d_grn, d_blu}); fs = 32'(d_fs);
    end else begin
      p = "small";
      rv = 32'(s_req_valid); rx = 32'(s_req_x); ry = 32'(s_req_y);
      de = 32'(s_de); hs = 32'(s_hsync); vs = 32'(s_vsync);
      rgb = 32'({s_red, s_grn, s_blu}); fs = 32'(s_fs);
    end
    check_eq({p, ".req_valid"},   rv,  32'(st0[d].valid));
    check_eq({p, ".req_x"},       rx,  32'(st0[d].x));
    check_eq({p, ".req_y"},       ry,  32'(st0[d].y));
    check_eq({p, ".de"},          de,  32'(st2[d].de));
    check_eq({p, ".hsync"},       hs,  32'(st2[d].hsync));
    check_eq({p, ".vsync"},       vs,  32'(st2[d].vsync));
    check_eq({p, ".rgb"},         rgb, 32'(st2[d].rgb));
    check_eq({p, ".frame_start"}, fs,  32'(st2[d].fs));
  endtask

  // One clock: advance the model on the rising edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      st0[d] = stage0(d);
      st2[d] = finalize(d, st1[d]);
      st1[d] = st0[d];
      if (!((d == 0) ? (d_reset && d_en) : (s_reset && s_en))) begin
        mh[d] = 0;
        mv[d] = 0;
      end else if (mh[d] == ha[d] + hf[d] + hsw[d] + hb[d] - 1) begin
        mh[d] = 0;
        mv[d] = (mv[d] == va[d] + vf[d] + vsw[d] + vb[d] - 1) ? 0 : mv[d] + 1;
      end else begin
        mh[d] = mh[d] + 1;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      st0[d] = stage0(d);
      check_dut(d);
    end
  endtask

  int  d_fs_first = -1, d_hs_rise = -1, d_hs_fall = -1, d_de_line0 = 0;
  int  s_hs_low = 0, s_fs_a = -1, s_fs_b = -1, s_fs_c = -1;
  bit  d_hs_prev = 1'b0;

  initial begin
    d_reset = 1'b0; d_en = 1'b1; d_mode = 2'd1; d_solid = 12'h3C5;
    s_reset = 1'b0; s_en = 1'b1; s_mode = 2'd3; s_solid = 12'h5A3;
    for (int d = 0; d < 2; d++) begin
      mh[d] = 0; mv[d] = 0; st1[d] = idle_st(); st2[d] = reset_out(d);
    end

    // Reset held for three clocks with en already high.
    repeat (3) step();
    d_reset = 1'b1;
    s_reset = 1'b1;

    for (int i = 1; i <= 4300; i++) begin
      step();
      if (d_fs && d_fs_first < 0) d_fs_first = i;
      if (d_hsync && !d_hs_prev && d_hs_rise < 0) d_hs_rise = i;
      if (!d_hsync && d_hs_prev && d_hs_rise >= 0 && d_hs_fall < 0) d_hs_fall = i;
      d_hs_prev = d_hsync;
      if (i >= 2 && i <= 1057 && d_de) d_de_line0++;
      if (i >= 2 && i <= 78 && !s_hsync) s_hs_low++;
      if (i > 2010 && s_fs) begin
        if (s_fs_a < 0) s_fs_a = i;
        else if (s_fs_b < 0) s_fs_b = i;
      end
      if (i > 3017 && s_fs && s_fs_c < 0) s_fs_c = i;

      case (i)
        500:  s_mode = 2'd2;
        1000: s_mode = 2'd0;
        1058: d_mode = 2'd0;
        1500: s_mode = 2'd1;
        2000: s_en = 1'b0;
        2010: s_en = 1'b1;
        2500: d_mode = 2'd2;
        3015: begin
          // Reset pulled mid-line, away from any clock edge.
          #2;
          s_reset = 1'b0;
          #1;
          check_eq("small.async_rst.de",        32'(s_de),        32'd0);
          check_eq("small.async_rst.rgb",       32'({s_red, s_grn, s_blu}), 32'd0);
          check_eq("small.async_rst.hsync",     32'(s_hsync),     32'd1);
          check_eq("small.async_rst.vsync",     32'(s_vsync),     32'd0);
          check_eq("small.async_rst.fs",        32'(s_fs),        32'd0);
          check_eq("small.async_rst.req_valid", 32'(s_req_valid), 32'd0);
          st1[1] = idle_st();
          st2[1] = reset_out(1);
          mh[1] = 0;
          mv[1] = 0;
        end
        3017: s_reset = 1'b1;
        3700: d_mode = 2'd3;
        default: ;
      endcase
    end

    check_eq("dflt.first_frame_start_clk", 32'(d_fs_first), 32'd2);
    check_eq("dflt.hsync_rise_clk",        32'(d_hs_rise),  32'd842);
    check_eq("dflt.hsync_width",           32'(d_hs_fall - d_hs_rise), 32'd128);
    check_eq("dflt.de_per_line",           32'(d_de_line0), 32'd800);
    check_eq("small.hsync_low_per_frame",  32'(s_hs_low),   32'd7);
    check_eq("small.fs_after_en_clk",      32'(s_fs_a),     32'd2012);
    check_eq("small.frame_period",         32'(s_fs_b - s_fs_a), 32'd77);
    check_eq("small.fs_after_reset_clk",   32'(s_fs_c),     32'd3019);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, hsync width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- COLOR_W, 4, bits per colour channel
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, pixel clock (40 MHz for the defaults)
- reset, in, 1, asynchronous, active-low reset
- en, in, 1, scan enable
- mode, in, 2, 0=external pixels, 1=colour bars, 2=checkerboard, 3=solid
- solid_rgb, in, 3*COLOR_W, colour used in mode 3
- req_valid, out, 1, pixel request is for the visible area
- req_x, out, clog2(H_ACTIVE), requested column
- req_y, out, clog2(V_ACTIVE), requested row
- pix_rgb, in, 3*COLOR_W, {r,g,b} returned exactly 1 clk after the request
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, display enable
- red, out, COLOR_W, red channel
- grn, out, COLOR_W, green channel
- blu, out, COLOR_W, blue channel
- frame_start, out, 1, 1-clk pulse aligned with the first de of a frame

Function
REQ-003 The block SHALL use H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-004 The counter h_cnt SHALL run 0..H_TOTAL-1 and wrap to 0.
REQ-005 The counter v_cnt SHALL increment when h_cnt wraps, run 0..V_TOTAL-1, and wrap to 0 when both counters wrap together.
REQ-006 The counter widths SHALL be clog2(H_TOTAL) and clog2(V_TOTAL), with no overflow at any legal parameter set.
REQ-007 Stage 0 SHALL drive req_valid = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE), req_x = h_cnt[low bits] and req_y = v_cnt[low bits]; req_x and req_y SHALL be 0 whenever req_valid is 0.
REQ-008 Hsync SHALL be active while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-009 Vsync SHALL be active while v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] for every h_cnt.
REQ-010 An active sync SHALL equal its *_POL level; an inactive sync SHALL equal the inverse.
REQ-011 The block SHALL register pix_rgb at stage 1 and drive all outputs from registers at stage 2, giving a fixed latency of 2 clk from the counter state to hsync/vsync/de/rgb/frame_start, all mutually aligned.
REQ-012 Pattern selection SHALL happen at stage 1 using the delayed x and y; in modes 1-3 pix_rgb SHALL be ignored.
REQ-013 Colour bars SHALL use 8 equal bars, bar index = x*8/H_ACTIVE, in the order white, yellow, cyan, green, magenta, red, blue, black; each component is all-ones or zero.
REQ-014 The checkerboard SHALL be white when x[4]^y[4]=0 and black otherwise (16x16 cells).
REQ-015 The red, grn and blu outputs SHALL be 0 whenever de=0, in every mode.
REQ-016 A mode change SHALL take effect on the next pixel with no glitch on syncs.
REQ-017 When en=0 the counters SHALL be held at 0, req_valid=0, and, 2 clk later, de=0, rgb=0, syncs inactive and frame_start=0.
REQ-018 When en rises, scanning SHALL start at h_cnt=0, v_cnt=0, and the first frame_start SHALL occur 2 clk after en is sampled high.
REQ-019 Deasserting en mid-frame SHALL abort the frame; the next frame SHALL start from 0,0.

Reset
REQ-020 While reset=0 the block SHALL clear all counters and pipeline registers asynchronously.
REQ-021 While reset is asserted the outputs SHALL be req_valid=0, req_x=0, req_y=0, de=0, rgb=0, frame_start=0, hsync=~HS_POL and vsync=~VS_POL.
REQ-022 The block SHALL treat reset release as synchronous to clk; the first count SHALL occur on the first clk edge with reset=1 and en=1.

Structure
REQ-023 A shared package vga_pkg SHALL hold the mode enum (PIX_EXT, PIX_BARS, PIX_CHECK, PIX_SOLID), the colour-bar constant table and a function that derives H_TOTAL/V_TOTAL.
REQ-024 One sub-module vga_timing SHALL contain the counters plus sync/active decode, and SHALL be reused by future blocks; pattern generation and the pipeline SHALL live in vga_scanout.
REQ-025 Elaboration SHALL fail if any porch or sync parameter is 0 or COLOR_W<1.

Verification
REQ-026 Reset held for 3 clk, then released with en=1 and defaults -> outputs at reset values during reset; frame_start at clk 2; exactly 663168 clk between frame_starts.
REQ-027 Defaults, one full frame -> 480000 de cycles; each line has an hsync pulse 128 clk wide, rising 842 clk after the line's first req_valid; vsync is active for exactly 4*1056 clk.
REQ-028 Mode 1 -> x=0..99 gives rgb=FFF, x=100..199 gives FF0, ..., x=700..799 gives 000; rgb=0 in blanking.
REQ-029 Mode 0 with pix_rgb driven as a function of (req_x,req_y) on the next clk -> each output pixel matches the requested coordinate at 2-clk alignment.
REQ-030 en dropped at v_cnt=300 for 10 clk, then restored -> outputs idle 2 clk after en falls; a new frame_start 2 clk after en rises; the full 663168-clk period follows.
REQ-031 Small config (H_ACTIVE=8, V_ACTIVE=4, all porches and syncs=1, HS_POL=0) -> h_cnt wraps at 11, frame is 7 lines, hsync is low 1 clk per line, and reset asserted mid-line clears everything asynchronously.
